// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: debounced PS/2 lines in, received byte and status strobes out.
// The master side drives the PS/2 lines; the receiver core is the slave.
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  rx_data,
        input  rx_valid,
        input  rx_err,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output rx_data,
        output rx_valid,
        output rx_err,
        output busy
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Partial frames are aborted after TIMEOUT clk cycles without a PS/2 clock falling edge.
module ps2_rx #(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic     clk,
    input  logic     rst,
    ps2_rx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q,    state_d;
    logic            clk_q,      clk_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [TO_W-1:0] timer_q,    timer_d;
    logic [7:0]      shift_q,    shift_d;
    logic            parity_q,   parity_d;
    logic [7:0]      rx_data_q,  rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q,   rx_err_d;

    logic f_edge;
    logic timeout;

    assign f_edge  = clk_q & ~bus.ps2_clk;
    // A falling edge in the same cycle as the timeout wins, so the frame keeps going.
    assign timeout = (state_q != IDLE) && !f_edge && (timer_q == TIMER_LAST);

    always_comb begin
        state_d    = state_q;
        clk_d      = bus.ps2_clk;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        if (state_q == IDLE || f_edge) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (f_edge && !bus.ps2_data) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            DATA: begin
                if (f_edge) begin
                    shift_d   = {bus.ps2_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (f_edge) begin
                    parity_d = bus.ps2_data;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (f_edge) begin
                    state_d = IDLE;
                    if ((^shift_q ^ parity_q) && bus.ps2_data) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d  = IDLE;
            timer_d  = '0;
            rx_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_q      <= 1'b1;
            bit_cnt_q  <= 3'd0;
            timer_q    <= '0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_q      <= clk_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: a table of whole frames plus directed sequences
// for post-reset edge, timeout abort, mid-frame reset and idle glitch.
module tb_ps2_rx;

    localparam int TIMEOUT = 20;
    localparam int TO_W    = 8;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    ps2_rx_if bus ();

    ps2_rx #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    int both_seen  = 0;
    int valid_exp  = 0;
    int err_exp    = 0;

    vec_t vecs [9];

    // Independent strobe tally, used to catch spurious or missing pulses.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) valid_seen++;
        if (bus.rx_err === 1'b1) err_seen++;
        if (bus.rx_valid === 1'b1 && bus.rx_err === 1'b1) both_seen++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        bus.ps2_clk  = 1'b1;
        tick(3);
        bus.ps2_clk  = 1'b0;
        tick(3);
    endtask

    task automatic wait_err(input int limit, output int first);
        first = -1;
        for (int n = 0; n <= limit; n++) begin
            @(negedge clk);
            if (bus.rx_err === 1'b1) begin
                first = n;
                break;
            end
        end
    endtask

    task automatic apply_frame(input vec_t v, input int idx);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v.data[i]);
        send_bit(v.par);
        bus.ps2_data = v.stop;
        bus.ps2_clk  = 1'b1;
        tick(3);
        check_output($sformatf("busy_before_stop[%0d]", idx), bus.busy, 1);
        bus.ps2_clk = 1'b0;
        @(negedge clk);
        check_output($sformatf("quiet_before_edge[%0d]", idx), {bus.rx_valid, bus.rx_err}, 0);
        @(negedge clk);
        check_output($sformatf("rx_valid[%0d]", idx), bus.rx_valid, v.exp_valid);
        check_output($sformatf("rx_err[%0d]", idx), bus.rx_err, v.exp_err);
        check_output($sformatf("rx_data[%0d]", idx), bus.rx_data, v.exp_data);
        if (v.exp_valid) valid_exp++;
        if (v.exp_err) err_exp++;
        @(negedge clk);
        check_output($sformatf("strobe_one_cycle[%0d]", idx), {bus.rx_valid, bus.rx_err}, 0);
        check_output($sformatf("busy_after[%0d]", idx), bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   first;
        int   vs0;
        int   es0;
        vec_t v1c;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
        vecs[4] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[7] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[8] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        v1c     = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};

        // Reset with the PS/2 clock still held low from upstream.
        rst          = 1'b1;
        bus.ps2_clk  = 1'b0;
        bus.ps2_data = 1'b0;
        tick(3);
        @(negedge clk);
        check_output("reset_rx_data", bus.rx_data, 8'h00);
        check_output("reset_rx_valid", bus.rx_valid, 0);
        check_output("reset_rx_err", bus.rx_err, 0);
        check_output("reset_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_reset_edge_busy", bus.busy, 1);
        wait_err(TIMEOUT + 5, first);
        check_output("post_reset_timeout_cycles", first, TIMEOUT);
        check_output("post_reset_timeout_busy", bus.busy, 0);
        check_output("post_reset_timeout_valid", bus.rx_valid, 0);
        err_exp++;
        @(posedge clk);
        #1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);

        for (int i = 0; i < 9; i++) apply_frame(vecs[i], i);

        // Falling edge with data high in IDLE is ignored.
        vs0 = valid_seen;
        es0 = err_seen;
        bus.ps2_data = 1'b1;
        bus.ps2_clk  = 1'b1;
        tick(3);
        bus.ps2_clk = 1'b0;
        tick(1);
        @(negedge clk);
        check_output("glitch_busy", bus.busy, 0);
        tick(4);
        check_output("glitch_no_strobe", (valid_seen - vs0) + (err_seen - es0), 0);
        bus.ps2_clk = 1'b1;
        tick(3);

        // Abandon a frame after 4 data bits and let it time out.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.ps2_data = 1'b1;
        bus.ps2_clk  = 1'b1;
        tick(3);
        bus.ps2_clk = 1'b0;
        @(posedge clk);
        #1;
        check_output("partial_busy", bus.busy, 1);
        wait_err(TIMEOUT + 5, first);
        check_output("timeout_cycles", first, TIMEOUT);
        check_output("timeout_busy", bus.busy, 0);
        check_output("timeout_rx_data_kept", bus.rx_data, 8'hA5);
        err_exp++;
        @(posedge clk);
        #1;
        bus.ps2_clk = 1'b1;
        tick(3);
        apply_frame(v1c, 100);

        // Reset in the middle of a frame after 5 data bits.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(2);
        check_output("midframe_busy", bus.busy, 1);
        vs0 = valid_seen;
        es0 = err_seen;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_output("midreset_busy", bus.busy, 0);
        check_output("midreset_rx_data", bus.rx_data, 8'h00);
        check_output("midreset_strobes", {bus.rx_valid, bus.rx_err}, 0);
        tick(5);
        check_output("midreset_no_strobe", (valid_seen - vs0) + (err_seen - es0), 0);
        apply_frame(v1c, 101);

        tick(3);
        check_output("never_both_strobes", both_seen, 0);
        check_output("total_valid_pulses", valid_seen, valid_exp);
        check_output("total_err_pulses", err_seen, err_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
